seq_chunk_adder: RTL and testbench
==================================

Name: seq_chunk_adder

Overview:
- Parametrised multi-cycle adder; successor to the fixed 4-bit ripple full adder.
- Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, with carry held in a register between chunks.
- Valid/ready handshakes on both sides, so it drops into streaming datapaths and testbench drivers.
- Produces sum, carry-out and signed overflow.

Parameters:
- WIDTH, 16: operand and sum width in bits; must be a multiple of CHUNK.
- CHUNK, 4: bits added per cycle; must be in 1..WIDTH.
- NCHUNK, WIDTH/CHUNK: derived local parameter, not overridable; number of RUN cycles.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A, unsigned or two's complement
- b  in  WIDTH  operand B
- cin  in  1  carry-in
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  registered result
- cout  out  1  carry out of bit WIDTH-1
- overflow  out  1  signed overflow flag

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset: asynchronous while rst=1.
  - state=IDLE; sum=0, cout=0, overflow=0, out_valid=0.
  - Chunk counter=0, carry register=0, operand registers=0.
  - in_ready=1 once in IDLE.
  - Reset mid-RUN or mid-DONE aborts the operation with no output; the pending result is lost.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready at a rising edge: latch a, b, cin; set carry register to cin; chunk counter to 0; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK) computes {c, s} = A_k + B_k + carry, a CHUNK+1-bit add.
  - s is written into sum bits k; c is written to the carry register; counter increments.
  - On the cycle with k=NCHUNK-1: cout=c; overflow=(A[WIDTH-1]==B[WIDTH-1]) && (s[CHUNK-1]!=A[WIDTH-1]); go to DONE.
- DONE:
  - out_valid=1; sum, cout and overflow are stable.
  - Hold all outputs while out_ready=0; no timeout.
  - On out_valid&&out_ready: go to IDLE and clear out_valid. sum/cout/overflow keep their last values until the next result.
- Latency:
  - Accept edge to out_valid high is NCHUNK+1 edges; WIDTH=16, CHUNK=4 gives 5.
  - Throughput is one result per NCHUNK+2 cycles with out_ready held high.
- Input changes while not in IDLE are ignored; operands are used only at the accept edge.
- Wrap-around: sum is modulo 2^WIDTH; the carry beyond WIDTH appears only on cout.
- CHUNK=WIDTH degenerates to one RUN cycle, equivalent to the plain 4-bit ripple adder for WIDTH=4.
- Illegal parameters (WIDTH%CHUNK!=0 or CHUNK=0) must be rejected at elaboration.

Optional Feature:
- Macro: SEQ_CHUNK_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), latched at the accept edge together with the operands.
  - sub=1: B is replaced by ~B and the initial carry by ~cin, giving sum = a - b - cin.
  - cout=1 means no borrow; overflow is computed on the inverted B.
  - sub=0 behaves exactly as add.
- Undefined: no sub port; add only; identical behaviour to sub=0.

Test Plan:
- Reset, then WIDTH=4, CHUNK=4; a=4'b1110, b=4'b0101, cin=0 -> after 2 edges sum=4'b0011, cout=1, overflow=0; a=4'b1111, b=4'b1111, cin=1 -> sum=4'b1111, cout=1, overflow=0.
- WIDTH=16, CHUNK=4; a=16'hFFFF, b=16'h0001, cin=0 -> out_valid exactly 5 edges after accept; sum=16'h0000, cout=1, overflow=0 (carry ripples through all 4 chunks).
- a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, cout=0, overflow=1; a=16'h8000, b=16'h8000 -> sum=16'h0000, cout=1, overflow=1.
- Back-pressure: out_ready=0 for 10 cycles after out_valid -> sum, cout and out_valid held; in_ready=0 throughout; second in_valid is not accepted until 1 edge after the out_ready handshake.
- Reset pulse during RUN (2nd chunk) -> out_valid never rises, sum=0, in_ready=1; a following op a=16'h1234, b=16'h4321 -> sum=16'h5555, cout=0.
- With SEQ_CHUNK_ADDER_SUB_EN defined, sub=1: a=16'h0005, b=16'h0007, cin=0 -> sum=16'hFFFE, cout=0, overflow=0; a=16'h8000, b=16'h0001 -> sum=16'h7FFF, cout=1, overflow=1.

Source files
------------

// File: rtl/seq_chunk_adder_if.sv
// Operand/result bundle for seq_chunk_adder: valid/ready operand side and valid/ready result side.
// No logic inside; latency and backpressure are defined by the attached adder.
// Optional SEQ_CHUNK_ADDER_SUB_EN adds the 1-bit sub request alongside the operands.
interface seq_chunk_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
   logic             sub;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   // Producer of operands / consumer of results (bench or upstream datapath).
   modport master (
      output in_valid, a, b, cin, out_ready,
`ifdef SEQ_CHUNK_ADDER_SUB_EN
      output sub,
`endif
      input  in_ready, out_valid, sum, cout, overflow
   );

   // The adder itself.
   modport slave (
      input  in_valid, a, b, cin, out_ready,
`ifdef SEQ_CHUNK_ADDER_SUB_EN
      input  sub,
`endif
      output in_ready, out_valid, sum, cout, overflow
   );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: WIDTH-bit a + b + cin, CHUNK bits per clock, carry held between chunks.
// Latency: out_valid rises NCHUNK+1 edges after (and including) the accept edge; one result per NCHUNK+2 cycles.
// Backpressure: in_ready low outside IDLE; result held in DONE until out_ready. Macro SEQ_CHUNK_ADDER_SUB_EN adds a - b - cin.
module seq_chunk_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input logic                clk,
   input logic                rst,
   seq_chunk_adder_if.slave   bus
);
   localparam bit BAD_PARAM = (CHUNK < 1) || (CHUNK > WIDTH) ||
                              ((WIDTH % ((CHUNK < 1) ? 1 : CHUNK)) != 0);
   localparam int NCHUNK    = (CHUNK < 1) ? 1 : WIDTH / CHUNK;
   localparam int CW        = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

   generate
      if (BAD_PARAM) begin : g_bad_param
         $fatal(1, "seq_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;          // already inverted when subtracting
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;
   logic             in_ready_q;
   logic             out_valid_q;

   logic [CHUNK-1:0] a_chunk_d;
   logic [CHUNK-1:0] b_chunk_d;
   logic [CHUNK:0]   add_d;        // {carry out of chunk, chunk sum}
   logic [WIDTH-1:0] b_in_d;
   logic             carry_in_d;

   // Operand conditioning at accept time: subtraction is add of ~b with inverted carry-in.
   always_comb begin
      b_in_d     = bus.b;
      carry_in_d = bus.cin;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
      if (bus.sub) begin
         b_in_d     = ~bus.b;
         carry_in_d = ~bus.cin;
      end
`endif
   end

   // One CHUNK-wide slice of the ripple add, selected by the chunk counter.
   always_comb begin
      a_chunk_d = a_q[cnt_q*CHUNK +: CHUNK];
      b_chunk_d = b_q[cnt_q*CHUNK +: CHUNK];
      add_d     = {1'b0, a_chunk_d} + {1'b0, b_chunk_d} + {{CHUNK{1'b0}}, carry_q};
   end

   // Control FSM and datapath registers; all outputs come straight from flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid && in_ready_q) begin
                  a_q        <= bus.a;
                  b_q        <= b_in_d;
                  carry_q    <= carry_in_d;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               sum_q[cnt_q*CHUNK +: CHUNK] <= add_d[CHUNK-1:0];
               carry_q                     <= add_d[CHUNK];
               if (cnt_q == LAST_CHUNK) begin
                  // Top chunk: its MSB is the sign bit of the result.
                  cout_q      <= add_d[CHUNK];
                  ovf_q       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                 (add_d[CHUNK-1] != a_q[WIDTH-1]);
                  cnt_q       <= '0;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder: a 4/4 instance (single RUN cycle) and a 16/4 instance.
// Checks reset state, latency, wrap/carry/overflow cases, back-pressure hold and reset abort.
// Subtract vectors run only when SEQ_CHUNK_ADDER_SUB_EN is defined.
module tb_seq_chunk_adder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   seq_chunk_adder_if #(.WIDTH(4))  if4 ();
   seq_chunk_adder_if #(.WIDTH(16)) if16 ();

   seq_chunk_adder #(.WIDTH(4),  .CHUNK(4)) u_dut4  (.clk(clk), .rst(rst), .bus(if4));
   seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic op4(input string tag, input logic [3:0] av, input logic [3:0] bv, input logic ci,
                      input logic [3:0] es, input logic ec, input logic eo);
      int lat = 0;
      @(negedge clk);
      check_val({tag, " in_ready"}, 32'(if4.in_ready), 1);
      if4.a = av; if4.b = bv; if4.cin = ci; if4.in_valid = 1'b1;
      @(posedge clk);
      #1 if4.in_valid = 1'b0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         @(negedge clk);
         if (if4.out_valid) lat = k;
         else @(posedge clk);
      end
      check_val({tag, " latency"}, 32'(lat), 2);
      check_val({tag, " sum"},  32'(if4.sum), 32'(es));
      check_val({tag, " cout"}, 32'(if4.cout), 32'(ec));
      check_val({tag, " ovf"},  32'(if4.overflow), 32'(eo));
      @(posedge clk);
      @(negedge clk);
      check_val({tag, " vld_clr"}, 32'(if4.out_valid), 0);
   endtask

   task automatic op16(input string tag, input logic [15:0] av, input logic [15:0] bv, input logic ci,
                       input logic [15:0] es, input logic ec, input logic eo);
      int lat = 0;
      @(negedge clk);
      check_val({tag, " in_ready"}, 32'(if16.in_ready), 1);
      if16.a = av; if16.b = bv; if16.cin = ci; if16.in_valid = 1'b1;
      @(posedge clk);
      #1 if16.in_valid = 1'b0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         @(negedge clk);
         if (if16.out_valid) lat = k;
         else @(posedge clk);
      end
      check_val({tag, " latency"}, 32'(lat), 5);
      check_val({tag, " sum"},  32'(if16.sum), 32'(es));
      check_val({tag, " cout"}, 32'(if16.cout), 32'(ec));
      check_val({tag, " ovf"},  32'(if16.overflow), 32'(eo));
      @(posedge clk);
      @(negedge clk);
      check_val({tag, " vld_clr"}, 32'(if16.out_valid), 0);
      check_val({tag, " rdy_back"}, 32'(if16.in_ready), 1);
      check_val({tag, " sum_kept"}, 32'(if16.sum), 32'(es));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      int lat;
      if4.in_valid = 1'b0;  if4.a = '0;  if4.b = '0;  if4.cin = 1'b0;  if4.out_ready = 1'b1;
      if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.cin = 1'b0; if16.out_ready = 1'b1;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
      if4.sub = 1'b0;
      if16.sub = 1'b0;
`endif
      // Reset state
      #12;
      check_val("rst sum16",  32'(if16.sum), 0);
      check_val("rst cout16", 32'(if16.cout), 0);
      check_val("rst ovf16",  32'(if16.overflow), 0);
      check_val("rst vld16",  32'(if16.out_valid), 0);
      check_val("rst rdy16",  32'(if16.in_ready), 1);
      check_val("rst sum4",   32'(if4.sum), 0);
      check_val("rst rdy4",   32'(if4.in_ready), 1);
      @(negedge clk);
      rst = 1'b0;

      // Single-chunk instance behaves like the plain 4-bit adder
      op4("w4_a", 4'b1110, 4'b0101, 1'b0, 4'b0011, 1'b1, 1'b0);
      op4("w4_b", 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0);

      // 16-bit, 4 chunks
      op16("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      op16("posovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      op16("negovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
      op16("cin",    16'h00FF, 16'h0F00, 1'b1, 16'h1000, 1'b0, 1'b0);

      // Back-pressure: operands change during RUN and must be ignored
      @(negedge clk);
      if16.out_ready = 1'b0;
      if16.a = 16'h1111; if16.b = 16'h2222; if16.cin = 1'b0; if16.in_valid = 1'b1;
      @(posedge clk);
      #1 if16.a = 16'h0001; if16.b = 16'h0002;
      lat = 0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         @(negedge clk);
         if (if16.out_valid) lat = k;
         else begin
            check_val("bp rdy_run", 32'(if16.in_ready), 0);
            @(posedge clk);
         end
      end
      check_val("bp latency", 32'(lat), 5);
      for (int i = 0; i < 10; i++) begin
         check_val("bp vld_hold", 32'(if16.out_valid), 1);
         check_val("bp sum_hold", 32'(if16.sum), 32'h3333);
         check_val("bp cout_hold", 32'(if16.cout), 0);
         check_val("bp rdy_low", 32'(if16.in_ready), 0);
         @(negedge clk);
      end
      if16.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_val("bp after_hs vld", 32'(if16.out_valid), 0);
      check_val("bp after_hs rdy", 32'(if16.in_ready), 1);
      @(posedge clk);
      #1 if16.in_valid = 1'b0;
      @(negedge clk);
      check_val("bp second_acc", 32'(if16.in_ready), 0);
      lat = 0;
      for (int k = 2; k <= 20 && lat == 0; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (if16.out_valid) lat = k;
      end
      check_val("bp2 latency", 32'(lat), 5);
      check_val("bp2 sum", 32'(if16.sum), 32'h0003);
      @(posedge clk);

      // Reset during RUN (second chunk) aborts the operation
      @(negedge clk);
      if16.a = 16'hAAAA; if16.b = 16'h5555; if16.cin = 1'b0; if16.in_valid = 1'b1;
      @(posedge clk);
      #1 if16.in_valid = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_val("abort sum", 32'(if16.sum), 0);
      check_val("abort vld", 32'(if16.out_valid), 0);
      check_val("abort rdy", 32'(if16.in_ready), 1);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (if16.out_valid) seen++;
      end
      check_val("abort no_vld", 32'(seen), 0);
      op16("post_rst", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);

`ifdef SEQ_CHUNK_ADDER_SUB_EN
      if16.sub = 1'b1;
      op16("sub_a", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
      op16("sub_b", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
      if16.sub = 1'b0;
      op16("sub_off", 16'h0005, 16'h0007, 1'b0, 16'h000C, 1'b0, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
